regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised successor to the 16x16 datapath register file: 2 combinational read ports, a dedicated special-register (SP) read, and mode-selected dual write ports.
- Adds explicit write addresses, optional hardwired-zero register 0, optional write-to-read bypass, and a per-register busy scoreboard with a lock/release handshake so the issue stage can detect hazards.
- Sits between decode (read/lock) and writeback (write/release).

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; register count NUM_REGS = 2**ADDR_W
- SP_IDX, 2**ADDR_W-1, index of the special register written by wr_data_sp
- ZERO_REG, 0, 1 = register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  read port 1 data (combinational)
- rd_data2  out  DATA_W  read port 2 data (combinational)
- rd_busy1  out  1  busy flag of rd_addr1 (combinational)
- rd_busy2  out  1  busy flag of rd_addr2 (combinational)
- rd_data_sp  out  DATA_W  contents of register SP_IDX (combinational)
- wr_mode  in  2  00 = port1 only; 01 = port1 + port2; 10 = port1 + SP; 11 = no write
- wr_addr1  in  ADDR_W  write port 1 address
- wr_data1  in  DATA_W  write port 1 data
- wr_addr2  in  ADDR_W  write port 2 address
- wr_data2  in  DATA_W  write port 2 data
- wr_data_sp  in  DATA_W  SP write data
- lock_en  in  1  request to mark lock_addr busy
- lock_addr  in  ADDR_W  register to lock
- lock_ok  out  1  lock_addr currently free; a lock request is accepted iff lock_en && lock_ok

Behaviour:
- Reset: clock and reset are a single clock `clk` and a synchronous active-high reset `rst`. When rst is high at a rising edge, all registers are cleared to 0 and all busy bits to 0. Writes and locks in that cycle are ignored. rst takes priority mid-operation; any in-flight lock is lost. After reset, all read outputs are 0, rd_busy1/2 = 0 and lock_ok = 1.
- Write enables (per cycle, rst low):
  - we1 = (wr_mode != 11)
  - we2 = (wr_mode == 01)
  - wesp = (wr_mode == 10)
- Writes take effect at the rising edge, so a stored value is visible one cycle later, or in the same cycle when BYPASS=1.
- Collision priority, highest first:
  - SP write over port 1 when wr_addr1 == SP_IDX.
  - Port 2 over port 1 when wr_addr1 == wr_addr2.
- ZERO_REG=1: any write to address 0 is discarded; reads of address 0 return 0; busy[0] is forced to 0; lock_ok is 1 for address 0 and the lock has no effect.
- Reads are combinational: rd_dataN = reg[rd_addrN] and rd_data_sp = reg[SP_IDX].
- BYPASS=1: if an enabled write in the current cycle targets rd_addrN (or SP_IDX for rd_data_sp), output the write data, using the same priority as storage. The ZERO_REG rule overrides bypass.
- BYPASS=0: reads return stored values only.
- Busy scoreboard, one bit per register:
  - Every enabled write clears busy[addr] of its target, including the SP write clearing busy[SP_IDX].
  - An accepted lock sets busy[lock_addr].
  - Lock and clear on the same address in the same cycle: the lock is only accepted if the register was already free, so the set wins and busy = 1 after the edge.
  - lock_en with lock_ok = 0 is ignored and the requester must retry; there is no queueing.
- rd_busyN = busy[rd_addrN]. With BYPASS=1, rd_busyN is forced to 0 when a write this cycle targets rd_addrN.
- lock_ok = !busy[lock_addr], from stored state only; it is not bypassed.
- Writes to non-busy registers are legal and simply update the value.
- No multi-cycle latency: read latency 0, write latency 1 edge.

Test Plan:
- Reset then read all addresses -> every rd_data = 0, rd_busy = 0, lock_ok = 1.
- wr_mode=01, wr_addr1=wr_addr2=5, wr_data1=16'h1111, wr_data2=16'h2222 -> reg5 = 16'h2222 next cycle. With BYPASS=1 and rd_addr1=5 in the same cycle, rd_data1 = 16'h2222; with BYPASS=0 it still reads the old value.
- wr_mode=10, wr_addr1=15, wr_data1=16'hAAAA, wr_data_sp=16'hBEEF (SP_IDX=15) -> rd_data_sp = 16'hBEEF.
- wr_mode=11 with arbitrary data -> no register changes.
- Lock sequence:
  - lock_en, lock_addr=3 -> rd_busy1 = 1 for rd_addr1=3; lock_ok = 0 for address 3.
  - A second lock on 3 is ignored.
  - Write to 3 -> busy clears and lock_ok = 1 next cycle.
  - Lock 3 and write 3 in the same cycle while free -> busy = 1 after the edge.
- ZERO_REG=1: write 16'hFFFF to address 0 and lock 0 -> rd_data = 0 and rd_busy = 0.
- Assert rst mid-lock with registers loaded -> all registers and busy bits clear at the next edge.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multiport register file: two combinational read ports plus an SP read, mode-selected
// dual write, optional hardwired zero register, write-to-read bypass and busy scoreboard.
module regfile_multiport #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int SP_IDX   = 2**ADDR_W-1,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic [DATA_W-1:0] rd_data_sp,
    input  logic [1:0]        wr_mode,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic [ADDR_W-1:0] wr_addr2,
    input  logic [DATA_W-1:0] wr_data2,
    input  logic [DATA_W-1:0] wr_data_sp,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    output logic              lock_ok
);

    localparam int                NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] SP_ADDR  = ADDR_W'(SP_IDX);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic              we1, we2, wesp;
    logic              lock_acc;
    logic [ADDR_W-1:0] rd_a   [3];
    logic [DATA_W-1:0] rd_val [3];
    logic              rd_bsy [2];

    // Enables are gated by rst so nothing is stored or forwarded in a reset cycle.
    always_comb begin
        we1  = !rst && (wr_mode != 2'b11);
        we2  = !rst && (wr_mode == 2'b01);
        wesp = !rst && (wr_mode == 2'b10);
    end

    always_comb begin
        if (ZERO_REG && lock_addr == '0) begin
            lock_ok = 1'b1;
        end else begin
            lock_ok = !busy_q[lock_addr];
        end
        lock_acc = !rst && lock_en && lock_ok;
    end

    // Assignment order encodes collision priority: SP over port 2 over port 1.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we1) begin
            regs_d[wr_addr1] = wr_data1;
            busy_d[wr_addr1] = 1'b0;
        end
        if (we2) begin
            regs_d[wr_addr2] = wr_data2;
            busy_d[wr_addr2] = 1'b0;
        end
        if (wesp) begin
            regs_d[SP_ADDR] = wr_data_sp;
            busy_d[SP_ADDR] = 1'b0;
        end
        if (lock_acc) begin
            busy_d[lock_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    function automatic logic wr_hit(
        input logic [ADDR_W-1:0] a,
        input logic              e1,
        input logic              e2,
        input logic              esp,
        input logic [ADDR_W-1:0] a1,
        input logic [ADDR_W-1:0] a2
    );
        return (e1 && a1 == a) || (e2 && a2 == a) || (esp && SP_ADDR == a);
    endfunction

    always_comb begin
        rd_a[0] = rd_addr1;
        rd_a[1] = rd_addr2;
        rd_a[2] = SP_ADDR;
        for (int unsigned i = 0; i < 3; i++) begin
            rd_val[i] = regs_q[rd_a[i]];
            if (BYPASS) begin
                if (wesp && SP_ADDR == rd_a[i]) begin
                    rd_val[i] = wr_data_sp;
                end else if (we2 && wr_addr2 == rd_a[i]) begin
                    rd_val[i] = wr_data2;
                end else if (we1 && wr_addr1 == rd_a[i]) begin
                    rd_val[i] = wr_data1;
                end
            end
            if (ZERO_REG && rd_a[i] == '0) begin
                rd_val[i] = '0;
            end
        end
        for (int unsigned i = 0; i < 2; i++) begin
            rd_bsy[i] = busy_q[rd_a[i]];
            if (BYPASS && wr_hit(rd_a[i], we1, we2, wesp, wr_addr1, wr_addr2)) begin
                rd_bsy[i] = 1'b0;
            end
            if (ZERO_REG && rd_a[i] == '0) begin
                rd_bsy[i] = 1'b0;
            end
        end
    end

    assign rd_data1   = rd_val[0];
    assign rd_data2   = rd_val[1];
    assign rd_data_sp = rd_val[2];
    assign rd_busy1   = rd_bsy[0];
    assign rd_busy2   = rd_bsy[1];

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: two instances (bypass/no zero reg, and zero reg/no bypass)
// driven in lockstep and checked against a reference model through a scoreboard queue.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_addr1, rd_addr2, wr_addr1, wr_addr2, lock_addr;
    logic [1:0]  wr_mode;
    logic [15:0] wr_data1, wr_data2, wr_data_sp;
    logic        lock_en;

    logic [15:0] rd1_o [2];
    logic [15:0] rd2_o [2];
    logic [15:0] sp_o  [2];
    logic        b1_o  [2];
    logic        b2_o  [2];
    logic        lok_o [2];

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    regfile_multiport #(.DATA_W(16), .ADDR_W(4), .SP_IDX(15), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd1_o[0]), .rd_data2(rd2_o[0]), .rd_busy1(b1_o[0]), .rd_busy2(b2_o[0]),
        .rd_data_sp(sp_o[0]), .wr_mode(wr_mode), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .wr_addr2(wr_addr2), .wr_data2(wr_data2), .wr_data_sp(wr_data_sp),
        .lock_en(lock_en), .lock_addr(lock_addr), .lock_ok(lok_o[0])
    );

    regfile_multiport #(.DATA_W(16), .ADDR_W(4), .SP_IDX(15), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd1_o[1]), .rd_data2(rd2_o[1]), .rd_busy1(b1_o[1]), .rd_busy2(b2_o[1]),
        .rd_data_sp(sp_o[1]), .wr_mode(wr_mode), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .wr_addr2(wr_addr2), .wr_data2(wr_data2), .wr_data_sp(wr_data_sp),
        .lock_en(lock_en), .lock_addr(lock_addr), .lock_ok(lok_o[1])
    );

    // Reference state, index 0 = u_dut_a, 1 = u_dut_b
    logic [15:0] m_reg  [2][16];
    logic        m_busy [2][16];

    typedef struct packed {
        logic [1:0][15:0] rd1;
        logic [1:0][15:0] rd2;
        logic [1:0][15:0] sp;
        logic [1:0]       b1;
        logic [1:0]       b2;
        logic [1:0]       lok;
    } exp_t;

    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic zr(input int d); return d == 1; endfunction
    function automatic logic bp(input int d); return d == 0; endfunction
    function automatic logic m_we1();  return !rst && wr_mode != 2'b11; endfunction
    function automatic logic m_we2();  return !rst && wr_mode == 2'b01; endfunction
    function automatic logic m_wesp(); return !rst && wr_mode == 2'b10; endfunction

    function automatic logic m_hit(input logic [3:0] a);
        return (m_we1() && wr_addr1 == a) || (m_we2() && wr_addr2 == a) || (m_wesp() && a == 4'd15);
    endfunction

    function automatic logic [15:0] exp_data(input int d, input logic [3:0] a);
        logic [15:0] v;
        v = m_reg[d][a];
        if (bp(d)) begin
            if (m_wesp() && a == 4'd15)               v = wr_data_sp;
            else if (m_we2() && wr_addr2 == a)        v = wr_data2;
            else if (m_we1() && wr_addr1 == a)        v = wr_data1;
        end
        if (zr(d) && a == 4'd0) v = 16'h0000;
        return v;
    endfunction

    function automatic logic exp_busy(input int d, input logic [3:0] a);
        if (zr(d) && a == 4'd0) return 1'b0;
        if (bp(d) && m_hit(a))  return 1'b0;
        return m_busy[d][a];
    endfunction

    function automatic logic exp_lok(input int d, input logic [3:0] a);
        if (zr(d) && a == 4'd0) return 1'b1;
        return !m_busy[d][a];
    endfunction

    // Push expectations for the current inputs, then pop and compare once outputs settle.
    task automatic sample();
        exp_t e, g;
        for (int d = 0; d < 2; d++) begin
            e.rd1[d] = exp_data(d, rd_addr1);
            e.rd2[d] = exp_data(d, rd_addr2);
            e.sp[d]  = exp_data(d, 4'd15);
            e.b1[d]  = exp_busy(d, rd_addr1);
            e.b2[d]  = exp_busy(d, rd_addr2);
            e.lok[d] = exp_lok(d, lock_addr);
        end
        sb.push_back(e);
        #2;
        g = sb.pop_front();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rd_data1[%0d] a=%0d", d, rd_addr1), {16'h0, rd1_o[d]}, {16'h0, g.rd1[d]});
            check_eq($sformatf("rd_data2[%0d] a=%0d", d, rd_addr2), {16'h0, rd2_o[d]}, {16'h0, g.rd2[d]});
            check_eq($sformatf("rd_data_sp[%0d]", d), {16'h0, sp_o[d]}, {16'h0, g.sp[d]});
            check_eq($sformatf("rd_busy1[%0d] a=%0d", d, rd_addr1), {31'h0, b1_o[d]}, {31'h0, g.b1[d]});
            check_eq($sformatf("rd_busy2[%0d] a=%0d", d, rd_addr2), {31'h0, b2_o[d]}, {31'h0, g.b2[d]});
            check_eq($sformatf("lock_ok[%0d] a=%0d", d, lock_addr), {31'h0, lok_o[d]}, {31'h0, g.lok[d]});
        end
    endtask

    // Advance one clock edge and update the model from the inputs held across it.
    task automatic tick();
        logic acc;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < 16; i++) begin
                    m_reg[d][i]  = 16'h0000;
                    m_busy[d][i] = 1'b0;
                end
            end else begin
                acc = lock_en && exp_lok(d, lock_addr);
                if (m_we1()) begin
                    if (!(m_wesp() && wr_addr1 == 4'd15) && !(m_we2() && wr_addr1 == wr_addr2))
                        m_reg[d][wr_addr1] = wr_data1;
                    m_busy[d][wr_addr1] = 1'b0;
                end
                if (m_we2()) begin
                    m_reg[d][wr_addr2]  = wr_data2;
                    m_busy[d][wr_addr2] = 1'b0;
                end
                if (m_wesp()) begin
                    m_reg[d][15]  = wr_data_sp;
                    m_busy[d][15] = 1'b0;
                end
                if (acc) m_busy[d][lock_addr] = 1'b1;
                if (zr(d)) begin
                    m_reg[d][0]  = 16'h0000;
                    m_busy[d][0] = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        sample();
        tick();
    endtask

    task automatic idle();
        rst = 1'b0; wr_mode = 2'b11; lock_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_mode = 2'b11; lock_en = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0; wr_addr1 = '0; wr_addr2 = '0; lock_addr = '0;
        wr_data1 = '0; wr_data2 = '0; wr_data_sp = '0;
        @(negedge clk);
        tick();
        idle();

        // Reset state over every address
        for (int a = 0; a < 16; a++) begin
            rd_addr1 = 4'(a); rd_addr2 = 4'(15 - a); lock_addr = 4'(a);
            sample();
            check_eq("reset_rd1", {16'h0, rd1_o[0]}, 32'h0);
            check_eq("reset_lock_ok", {31'h0, lok_o[1]}, 32'h1);
            tick();
        end

        // Preload r5, then dual write with port-2 priority
        wr_mode = 2'b00; wr_addr1 = 4'd5; wr_data1 = 16'h0055;
        cycle();
        wr_mode = 2'b01; wr_addr1 = 4'd5; wr_addr2 = 4'd5;
        wr_data1 = 16'h1111; wr_data2 = 16'h2222; rd_addr1 = 4'd5;
        sample();
        check_eq("dual_bypass", {16'h0, rd1_o[0]}, 32'h2222);
        check_eq("dual_nobypass", {16'h0, rd1_o[1]}, 32'h0055);
        tick();
        idle();
        sample();
        check_eq("dual_stored_a", {16'h0, rd1_o[0]}, 32'h2222);
        check_eq("dual_stored_b", {16'h0, rd1_o[1]}, 32'h2222);
        tick();

        // SP write beats port 1 on the SP address
        wr_mode = 2'b10; wr_addr1 = 4'd15; wr_data1 = 16'hAAAA; wr_data_sp = 16'hBEEF;
        sample();
        check_eq("sp_bypass", {16'h0, sp_o[0]}, 32'hBEEF);
        tick();
        idle();
        sample();
        check_eq("sp_stored_a", {16'h0, sp_o[0]}, 32'hBEEF);
        check_eq("sp_stored_b", {16'h0, sp_o[1]}, 32'hBEEF);
        tick();

        // No-write mode with arbitrary data
        wr_addr1 = 4'd5; wr_addr2 = 4'd6; wr_data1 = 16'hDEAD; wr_data2 = 16'hCAFE; wr_data_sp = 16'h1234;
        for (int a = 0; a < 16; a++) begin
            rd_addr1 = 4'(a); rd_addr2 = 4'(a ^ 5);
            cycle();
        end

        // Lock sequence on r3
        lock_en = 1'b1; lock_addr = 4'd3;
        cycle();
        idle(); rd_addr1 = 4'd3;
        sample();
        check_eq("lock_busy_a", {31'h0, b1_o[0]}, 32'h1);
        check_eq("lock_busy_b", {31'h0, b1_o[1]}, 32'h1);
        check_eq("lock_ok_busy", {31'h0, lok_o[0]}, 32'h0);
        tick();
        lock_en = 1'b1;
        cycle();
        idle(); wr_mode = 2'b00; wr_addr1 = 4'd3; wr_data1 = 16'h3333;
        sample();
        check_eq("wr_clear_bypass", {31'h0, b1_o[0]}, 32'h0);
        check_eq("wr_clear_nobypass", {31'h0, b1_o[1]}, 32'h1);
        tick();
        idle();
        sample();
        check_eq("released_lock_ok", {31'h0, lok_o[1]}, 32'h1);
        tick();
        lock_en = 1'b1; wr_mode = 2'b00; wr_data1 = 16'h4444;
        cycle();
        idle();
        sample();
        check_eq("lock_wins_a", {31'h0, b1_o[0]}, 32'h1);
        check_eq("lock_wins_b", {31'h0, b1_o[1]}, 32'h1);
        tick();

        // Zero register: write all-ones and lock r0
        wr_mode = 2'b00; wr_addr1 = 4'd0; wr_data1 = 16'hFFFF;
        lock_en = 1'b1; lock_addr = 4'd0; rd_addr1 = 4'd0;
        cycle();
        idle();
        sample();
        check_eq("zero_data", {16'h0, rd1_o[1]}, 32'h0);
        check_eq("zero_busy", {31'h0, b1_o[1]}, 32'h0);
        check_eq("nonzero_data", {16'h0, rd1_o[0]}, 32'hFFFF);
        tick();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 39) == 0);
            wr_mode    = rst ? 2'b11 : 2'($urandom_range(0, 3));
            lock_en    = rst ? 1'b0 : 1'($urandom_range(0, 1));
            wr_addr1   = 4'($urandom_range(0, 15));
            wr_addr2   = ($urandom_range(0, 3) == 0) ? wr_addr1 : 4'($urandom_range(0, 15));
            rd_addr1   = ($urandom_range(0, 2) == 0) ? wr_addr1 : 4'($urandom_range(0, 15));
            rd_addr2   = ($urandom_range(0, 2) == 0) ? wr_addr2 : 4'($urandom_range(0, 15));
            lock_addr  = ($urandom_range(0, 2) == 0) ? wr_addr1 : 4'($urandom_range(0, 15));
            wr_data1   = 16'($urandom);
            wr_data2   = 16'($urandom);
            wr_data_sp = 16'($urandom);
            cycle();
        end

        // Reset while registers are loaded and r7 is locked
        idle(); wr_mode = 2'b01; wr_addr1 = 4'd7; wr_addr2 = 4'd9; wr_data1 = 16'h7777; wr_data2 = 16'h9999;
        cycle();
        idle(); lock_en = 1'b1; lock_addr = 4'd7;
        cycle();
        idle(); rst = 1'b1;
        cycle();
        idle();
        for (int a = 0; a < 16; a++) begin
            rd_addr1 = 4'(a); rd_addr2 = 4'(a); lock_addr = 4'(a);
            sample();
            if (a == 7) begin
                check_eq("rst_busy7", {31'h0, b1_o[0]}, 32'h0);
                check_eq("rst_data7", {16'h0, rd1_o[0]}, 32'h0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
